gfx_bus_master: RTL
===================

// Module: gfx_bus_master
// PURPOSE
// - Host-side initiator for the graphics adapter register bus (cs/rs/wren/data, 1 MHz phase clock).
// - Accepts queued register read/write commands, generates the free-running phase clock plus
//   cs_n/rs/wren_n/data bus cycles (one transaction per phase period), returns read data.
// - Used in the test system and on-board self-test to drive text/mode registers without a CPU.
// PARAMETERS
// HALF      25  clk cycles per phase-clock half period (50 MHz -> 1 MHz); legal range >= 4
// HOLD_CYC  2   clk cycles after phase fall that cs_n/rs/wren_n/data are held; 1 <= HOLD_CYC < HALF
// FIFO_DEPTH 4  command FIFO entries (power of 2)
// PORTS
// clk          in   1  system clock
// rst_n        in   1  asynchronous, active-low reset
// cmd_valid    in   1  command present
// cmd_ready    out  1  FIFO not full; a command is accepted on clk when cmd_valid & cmd_ready
// cmd_we       in   1  1 = write, 0 = read
// cmd_rs       in   4  register select
// cmd_wdata    in   8  write data
// rd_valid     out  1  one-clk pulse: read data valid
// rd_rs        out  4  register select of the completed read
// rd_data      out  8  sampled read data
// busy         out  1  FIFO non-empty or bus transaction in flight
// bus_clk_o    out  1  phase clock to the adapter clk_ext1
// bus_cs_n     out  1  chip select, active low
// bus_rs       out  4  register select
// bus_wren_n   out  1  write enable, active low
// bus_data_o   out  8  write data (top level drives inout data_bi when bus_data_oe)
// bus_data_oe  out  1  data output enable
// bus_data_i   in   8  data bus input
// BEHAVIOUR
// - Reset (async, immediate): div_cnt=0, bus_clk_o=0, bus_cs_n=1, bus_wren_n=1, bus_rs=0,
//   bus_data_o=0, bus_data_oe=0, rd_valid=0, rd_rs=0, rd_data=0, FIFO empty, state IDLE,
//   cmd_ready=1 after release; busy=0. Reset mid-transaction aborts it and flushes the FIFO.
// - Phase gen: div_cnt counts 0..HALF-1, wraps; bus_clk_o toggles on the wrap. Free-running always.
//   Period = 2*HALF clks. "Load point" = clk where bus_clk_o==0 and div_cnt==HOLD_CYC-1.
// - All bus outputs registered; a value decided at the load point is visible the next clk.
// - FSM states: IDLE, SETUP (phase low, cs asserted), STROBE (phase high).
//   IDLE: at load point, if FIFO non-empty -> pop head, drive cs_n=0, rs, wren_n=~we,
//     data_o=wdata, data_oe=we -> SETUP. Else outputs stay released.
//   SETUP: on phase rise -> STROBE. Bus signals unchanged.
//   STROBE: on last clk of high phase (div_cnt==HALF-1) for reads, capture bus_data_i into rd_data,
//     rd_rs=bus_rs; rd_valid pulses 1 clk on the following clk. On phase fall -> hold window:
//     all bus signals unchanged for HOLD_CYC clks (adapter latches data on chipclk fall).
//     At the load point: FIFO non-empty -> pop next, update signals, cs_n stays 0 -> SETUP;
//     else cs_n=1, wren_n=1, data_oe=0 -> IDLE (bus_rs, bus_data_o keep last value).
// - Throughput: one transaction per phase period back-to-back; cs_n held low continuously.
// - FIFO: push and pop in the same clk both occur, count unchanged. cmd_ready = !full
//   (combinational from count); push while full is ignored. Occupancy counts only queued
//   entries; in-flight command is held in bus registers, so FIFO_DEPTH+1 commands can be pending.
// - busy = FIFO non-empty | state != IDLE.
// - Read data not sampled for writes; rd_valid never asserted for writes.
// TESTING
// - HALF=4,HOLD_CYC=1; idle 40 clks -> bus_clk_o period 8 clks, bus_cs_n=1, data_oe=0, busy=0.
// - Write rs=1 data=0x41 -> cs_n low, wren_n=0, rs=1, data_o=0x41, oe=1 for exactly 8 clks
//   spanning one full phase-high half; then released, busy=0.
// - Read rs=4, bus_data_i=0xA5 during phase high -> single rd_valid pulse, rd_rs=4, rd_data=0xA5;
//   wren_n=1, data_oe=0 throughout.
// - Push 6 writes rs=3,data=0..5 back-to-back -> cmd_ready low after 5 accepted; 6th held until
//   ready; cs_n continuously low 6 phase periods, data_o 0..5 in order, each updated at load point.
// - Assert rst_n=0 mid-STROBE with 3 queued -> outputs at reset values same clk; after release
//   no bus activity, cmd_ready=1, busy=0.
// - Push during pop with FIFO at 3 -> count stays 3, order preserved.

Source files
------------

// File: rtl/gfx_bus_master_if.sv
// Command, read-return and adapter bus signals of the graphics register bus master.
interface gfx_bus_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [3:0] cmd_rs;
    logic [7:0] cmd_wdata;
    logic       rd_valid;
    logic [3:0] rd_rs;
    logic [7:0] rd_data;
    logic       busy;
    logic       bus_clk_o;
    logic       bus_cs_n;
    logic [3:0] bus_rs;
    logic       bus_wren_n;
    logic [7:0] bus_data_o;
    logic       bus_data_oe;
    logic [7:0] bus_data_i;

    // Bus master side
    modport master (
        input  cmd_valid, cmd_we, cmd_rs, cmd_wdata, bus_data_i,
        output cmd_ready, rd_valid, rd_rs, rd_data, busy,
        output bus_clk_o, bus_cs_n, bus_rs, bus_wren_n, bus_data_o, bus_data_oe
    );

    // Command source / adapter side
    modport slave (
        output cmd_valid, cmd_we, cmd_rs, cmd_wdata, bus_data_i,
        input  cmd_ready, rd_valid, rd_rs, rd_data, busy,
        input  bus_clk_o, bus_cs_n, bus_rs, bus_wren_n, bus_data_o, bus_data_oe
    );
endinterface

// File: rtl/gfx_bus_master.sv
// Host-side initiator for the graphics adapter register bus: queues register read/write
// commands and plays them out one per phase-clock period on cs_n/rs/wren_n/data.
module gfx_bus_master #(
    parameter int unsigned HALF       = 25,  // clk cycles per phase half period, >= 4
    parameter int unsigned HOLD_CYC   = 2,   // hold after phase fall, 1 <= HOLD_CYC < HALF
    parameter int unsigned FIFO_DEPTH = 4    // power of 2, >= 2
) (
    input  logic             clk,
    input  logic             rst_n,
    gfx_bus_master_if.master io_bus
);
    localparam int unsigned DIV_W = $clog2(HALF);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic       we;
        logic [3:0] rs;
        logic [7:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe} state_e;

    // Phase generator
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_bus_clk;
    logic             w_div_wrap;
    logic             w_rise;
    logic             w_load_pt;
    logic             w_last_high;

    // Command FIFO
    cmd_t             r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_cmd_ready;
    logic             w_fifo_nempty;
    logic             w_push;
    cmd_t             w_cmd_in;
    cmd_t             w_head;

    // Control
    state_e           r_state;
    state_e           w_state_d;
    logic             w_pop;
    logic             w_release;
    logic             w_capture;

    // Registered bus and read-return outputs
    logic             r_bus_cs_n;
    logic [3:0]       r_bus_rs;
    logic             r_bus_wren_n;
    logic [7:0]       r_bus_data_o;
    logic             r_bus_data_oe;
    logic             r_rd_valid;
    logic [3:0]       r_rd_rs;
    logic [7:0]       r_rd_data;

    assign w_div_wrap  = (r_div_cnt == DIV_W'(HALF - 1));
    assign w_rise      = w_div_wrap && !r_bus_clk;
    assign w_last_high = w_div_wrap && r_bus_clk;
    assign w_load_pt   = !r_bus_clk && (r_div_cnt == DIV_W'(HOLD_CYC - 1));

    // Free-running phase clock: toggles every HALF clks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_bus_clk <= 1'b0;
        end else if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_bus_clk <= ~r_bus_clk;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    assign w_cmd_ready   = (r_count != CNT_W'(FIFO_DEPTH));
    assign w_fifo_nempty = (r_count != '0);
    assign w_push        = io_bus.cmd_valid && w_cmd_ready;
    assign w_cmd_in      = '{we: io_bus.cmd_we, rs: io_bus.cmd_rs, wdata: io_bus.cmd_wdata};
    assign w_head        = r_fifo_mem[r_rd_ptr];

    // FIFO storage; entries need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= w_cmd_in;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // FSM next state; STROBE persists through the hold window until the load point
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_load_pt && w_fifo_nempty) begin
                    w_state_d = StSetup;
                end
            end
            StSetup: begin
                if (w_rise) begin
                    w_state_d = StStrobe;
                end
            end
            StStrobe: begin
                if (w_load_pt) begin
                    w_state_d = w_fifo_nempty ? StSetup : StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // FSM control outputs: pop/load, bus release and read capture strobes
    always_comb begin
        w_pop     = 1'b0;
        w_release = 1'b0;
        w_capture = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_pop = w_load_pt && w_fifo_nempty;
            end
            StSetup: begin
                w_pop = 1'b0;
            end
            StStrobe: begin
                // wren_n high marks the in-flight command as a read
                w_capture = w_last_high && r_bus_wren_n;
                w_pop     = w_load_pt && w_fifo_nempty;
                w_release = w_load_pt && !w_fifo_nempty;
            end
            default: begin
                w_pop = 1'b0;
            end
        endcase
    end

    // Bus output registers; rs and data_o keep their last value after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_cs_n    <= 1'b1;
            r_bus_rs      <= '0;
            r_bus_wren_n  <= 1'b1;
            r_bus_data_o  <= '0;
            r_bus_data_oe <= 1'b0;
        end else if (w_pop) begin
            r_bus_cs_n    <= 1'b0;
            r_bus_rs      <= w_head.rs;
            r_bus_wren_n  <= ~w_head.we;
            r_bus_data_o  <= w_head.wdata;
            r_bus_data_oe <= w_head.we;
        end else if (w_release) begin
            r_bus_cs_n    <= 1'b1;
            r_bus_wren_n  <= 1'b1;
            r_bus_data_oe <= 1'b0;
        end
    end

    // Read return: sample on the last clk of phase high, pulse rd_valid the next clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_rs    <= '0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_capture;
            if (w_capture) begin
                r_rd_rs   <= r_bus_rs;
                r_rd_data <= io_bus.bus_data_i;
            end
        end
    end

    assign io_bus.cmd_ready   = w_cmd_ready;
    assign io_bus.busy        = w_fifo_nempty || (r_state != StIdle);
    assign io_bus.rd_valid    = r_rd_valid;
    assign io_bus.rd_rs       = r_rd_rs;
    assign io_bus.rd_data     = r_rd_data;
    assign io_bus.bus_clk_o   = r_bus_clk;
    assign io_bus.bus_cs_n    = r_bus_cs_n;
    assign io_bus.bus_rs      = r_bus_rs;
    assign io_bus.bus_wren_n  = r_bus_wren_n;
    assign io_bus.bus_data_o  = r_bus_data_o;
    assign io_bus.bus_data_oe = r_bus_data_oe;

endmodule
